// File: rtl/qoi_types.sv
// Shared QOI types and constants for the encoder back end.
// Holds the header/trailer constants and the stream writer state encoding.
package qoi_types;

  typedef logic [7:0] byte_t;

  localparam logic [31:0] QOI_MAGIC   = 32'h716F6966;
  localparam int          QOI_HDR_LEN = 14;
  localparam int          QOI_END_LEN = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_BODY,
    ST_TRAILER,
    ST_DONE
  } wr_state_e;

  // Header byte at position idx: magic, width and height big-endian, channels, colorspace.
  function automatic byte_t hdr_byte(input logic [3:0] idx, input logic [31:0] w,
                                     input logic [31:0] h, input byte_t ch, input byte_t cs);
    case (idx)
      4'd0:    return QOI_MAGIC[31:24];
      4'd1:    return QOI_MAGIC[23:16];
      4'd2:    return QOI_MAGIC[15:8];
      4'd3:    return QOI_MAGIC[7:0];
      4'd4:    return w[31:24];
      4'd5:    return w[23:16];
      4'd6:    return w[15:8];
      4'd7:    return w[7:0];
      4'd8:    return h[31:24];
      4'd9:    return h[23:16];
      4'd10:   return h[15:8];
      4'd11:   return h[7:0];
      4'd12:   return ch;
      default: return cs;
    endcase
  endfunction

endpackage

// File: rtl/qoi_stream_writer.sv
// Writes a complete QOI file (header, encoder payload, end marker) into byte-wide
// memory through a single output register with a valid/ready write handshake.
module qoi_stream_writer
  import qoi_types::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       width,
  input  logic [31:0]       height,
  input  byte_t             channels,
  input  byte_t             colorspace,
  input  byte_t             in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output byte_t             mem_data,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       byte_count,
  output logic              overflow
);

  wr_state_e         state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [31:0]       width_q, width_d, height_q, height_d;
  byte_t             channels_q, channels_d, colorspace_q, colorspace_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W:0]   loads_q, loads_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  byte_t             mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;
  logic [31:0]       byte_count_q, byte_count_d;

  logic              slot_free, wr_done, load, ld_first, ovf_base;
  byte_t             ld_data;
  logic [ADDR_W-1:0] ld_addr;
  logic [ADDR_W:0]   loads_base;
  logic [31:0]       cnt_base;

  assign slot_free = !mem_we_q || mem_ready;
  assign wr_done   = mem_we_q && mem_ready;
  assign in_ready  = (state_q == ST_BODY) && slot_free;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    width_d      = width_q;
    height_d     = height_q;
    channels_d   = channels_q;
    colorspace_d = colorspace_q;
    done_d       = 1'b0;
    load         = 1'b0;
    ld_first     = 1'b0;
    ld_data      = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Header byte 0 loads on the start edge so mem_we rises the next cycle.
          width_d      = width;
          height_d     = height;
          channels_d   = channels;
          colorspace_d = colorspace;
          load         = 1'b1;
          ld_first     = 1'b1;
          ld_data      = hdr_byte(4'd0, width, height, channels, colorspace);
          idx_d        = 4'd1;
          state_d      = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_data = hdr_byte(idx_q, width_q, height_q, channels_q, colorspace_q);
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'(QOI_HDR_LEN - 1)) state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        if (in_valid && slot_free) begin
          load    = 1'b1;
          ld_data = in_data;
          if (in_last) begin
            state_d = ST_TRAILER;
            idx_d   = 4'd0;
          end
        end
      end
      ST_TRAILER: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_data = (idx_q == 4'(QOI_END_LEN - 1)) ? 8'h01 : 8'h00;
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'(QOI_END_LEN - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (wr_done) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new file restarts addressing, load counting and the sticky flags.
    ld_addr    = ld_first ? base_addr : next_addr_q;
    loads_base = ld_first ? '0 : loads_q;
    ovf_base   = ld_first ? 1'b0 : overflow_q;
    cnt_base   = ld_first ? 32'd0 : byte_count_q;

    byte_count_d = cnt_base + (wr_done ? 32'd1 : 32'd0);
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    next_addr_d  = next_addr_q;
    loads_d      = loads_base;
    overflow_d   = ovf_base;
    if (load) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = ld_addr;
      mem_data_d  = ld_data;
      next_addr_d = ld_addr + ADDR_W'(1);
      // loads_base[ADDR_W] set means 2^ADDR_W loads already happened; saturate there.
      loads_d     = loads_base[ADDR_W] ? loads_base : loads_base + (ADDR_W+1)'(1);
      overflow_d  = ovf_base | loads_base[ADDR_W];
    end else if (slot_free) begin
      mem_we_d = 1'b0;
    end

    busy_d = (state_d == ST_HEADER) || (state_d == ST_BODY) || (state_d == ST_TRAILER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      width_q      <= '0;
      height_q     <= '0;
      channels_q   <= '0;
      colorspace_q <= '0;
      next_addr_q  <= '0;
      loads_q      <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      width_q      <= width_d;
      height_q     <= height_d;
      channels_q   <= channels_d;
      colorspace_q <= colorspace_d;
      next_addr_q  <= next_addr_d;
      loads_q      <= loads_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule

// File: doc/qoi_stream_writer.md
Name: qoi_stream_writer

Overview:
- Downstream stage of the QOI encoder: accepts encoded QOI bytes over a valid/ready byte stream and writes a complete QOI file image into byte-wide memory.
- Emits the 14-byte QOI header, the encoder payload unchanged, then the 8-byte end marker, at consecutive addresses from a base address.
- Reports total bytes written and a done pulse so the 6502 host can read back file length.

Parameters:
- ADDR_W, 16, width of mem_addr and base_addr; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a file, sampled only in IDLE
- base_addr  input  ADDR_W  first write address, latched on accepted start
- width  input  32  image width in pixels, latched on start
- height  input  32  image height in pixels, latched on start
- channels  input  8  header channels byte (3 or 4), latched on start
- colorspace  input  8  header colorspace byte, latched on start
- in_data  input  8  (byte_t) encoded byte from encoder
- in_valid  input  1  in_data valid
- in_last  input  1  qualifies the final payload byte
- in_ready  output  1  byte accepted when in_valid && in_ready at clk edge
- mem_addr  output  ADDR_W  write address
- mem_data  output  8  (byte_t) write data
- mem_we  output  1  write request; held with addr/data stable until mem_ready
- mem_ready  input  1  write completes on edge where mem_we && mem_ready
- busy  output  1  high in HEADER, BODY, TRAILER
- done  output  1  one-cycle pulse when last trailer byte is written
- byte_count  output  32  bytes written this file; held after done until next start
- overflow  output  1  sticky; set when byte_count exceeds 2^ADDR_W

Behaviour:
- Reset (rst low, async): state IDLE; mem_we, in_ready, busy, done, overflow = 0; mem_addr, mem_data, byte_count, index counter = 0.
- FSM: IDLE, HEADER, BODY, TRAILER, DONE.
- Output register: single stage holding mem_addr/mem_data/mem_we. "slot_free" = !mem_we || mem_ready. A new byte loads only when slot_free; on load mem_we=1 and mem_addr = next address; if slot_free with nothing to load, mem_we drops to 0.
- Address and count: each completed write (mem_we && mem_ready) increments byte_count; each load uses next address = base_addr + loads so far, mod 2^ADDR_W.
- IDLE: start latches fields, clears byte_count and overflow, index counter = 0, goes to HEADER. First mem_we is asserted in the cycle after start. start outside IDLE is ignored.
- HEADER: loads bytes in order 0x71 0x6F 0x69 0x66, width[31:24], [23:16], [15:8], [7:0], then height in the same big-endian order, channels, colorspace. After the 14th load, go to BODY.
- BODY: in_ready = slot_free, combinational. An accepted byte loads into the output register the same edge, with no reordering, dropping or duplication under any mem_ready pattern. Accepting a byte with in_last=1 sends the FSM to TRAILER with index counter = 0. in_data is never inspected.
- TRAILER: loads 0x00 x7 then 0x01. After the 8th load, go to DONE.
- DONE: waits until the final write completes (mem_we && mem_ready), pulses done for exactly one cycle, then returns to IDLE. busy is low in DONE.
- in_ready = 0 in every state other than BODY.
- Empty payload is legal: in_last on the first body byte gives a file of 14+1+8 bytes.
- overflow: set when a load would be the (2^ADDR_W+1)-th of the file. Writes continue, wrapping the address.
- Reset mid-operation aborts immediately. No done pulse; memory contents are undefined.

Decomposition:
- qoi_types: add QOI_MAGIC (32'h716F6966), QOI_HDR_LEN=14, QOI_END_LEN=8, and the writer state enum typedef. Reuse byte_t.
- No sub-module. The output register is inline; a separate skid stage is unnecessary.

Test Plan:
- 1x1 image: width=1, height=1, channels=4, colorspace=0, base 0x0200, body FE 10 20 30 (last on 30), mem_ready=1.
  - Writes at 0x0200..0x0219: 71 6F 69 66 00 00 00 01 00 00 00 01 04 00 FE 10 20 30 00 00 00 00 00 00 00 01.
  - byte_count=26, one done pulse, first mem_we one cycle after start.
- Backpressure: same stimulus, mem_ready random ~50%, in_valid gapped.
  - Identical 26-byte sequence; addr/data stable while mem_we && !mem_ready.
  - in_ready never high outside BODY.
- Big-endian fields: width=0x00012345, height=0xDEADBEEF.
  - Header bytes 4..11 = 00 01 23 45 DE AD BE EF.
- start pulsed during BODY: ignored; latched fields and addresses unchanged.
  - A second start in IDLE after done restarts at its new base with byte_count cleared.
- Reset mid-BODY: rst low for 1 cycle after 5 body bytes.
  - All outputs at reset values asynchronously, no done pulse.
  - Next start produces a correct full file.
- Wrap: ADDR_W=4, base 0xA, 20-byte stream.
  - Addresses wrap 0xF -> 0x0; overflow set at the 17th write and sticky; byte_count=42.
